// File: rtl/instruction_fetch_memory_if.sv
// Fetch request/response handshake between an instruction consumer (master)
// and the fetch memory (slave).
interface instruction_fetch_memory_if #(
  parameter int unsigned ADDR_W = 64
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_inst;
  logic              resp_fault;

  modport master (
    output req_valid,
    output req_addr,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_inst,
    input  resp_fault
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_inst,
    output resp_fault
  );

endinterface

// File: rtl/instruction_fetch_memory.sv
// Byte-programmable instruction memory with a single-stage fetch pipeline.
// Misaligned or out-of-range fetches return NOP_INST with resp_fault set.
module instruction_fetch_memory #(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned ADDR_W    = 64,
  parameter logic [31:0] NOP_INST  = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  instruction_fetch_memory_if.slave    bus,
  input  logic                         prog_en,
  input  logic [$clog2(MEM_BYTES)-1:0] prog_addr,
  input  logic [7:0]                   prog_byte,
  output logic [15:0]                  fetch_cnt
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e      state_q;
  logic [31:0] inst_q;
  logic        fault_q;
  logic [15:0] cnt_q;

  // Not reset: program contents survive a reset of the fetch pipeline.
  logic [7:0] mem_q [MEM_BYTES] = '{default: 8'h00};

  logic          accept;
  logic          fault;
  logic [AW-1:0] base;
  logic [31:0]   word;

  assign bus.req_ready = (state_q == StEmpty) || bus.resp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  assign base  = bus.req_addr[AW-1:0];
  assign fault = (base[1:0] != 2'b00) || (bus.req_addr > LAST_WORD);

  // Base is word-aligned whenever the result is used, so OR selects the byte lane.
  assign word = {mem_q[base | AW'(3)], mem_q[base | AW'(2)],
                 mem_q[base | AW'(1)], mem_q[base]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      inst_q  <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_q <= StFull;
        StFull:  if (bus.resp_ready && !accept) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
      if (accept) begin
        inst_q  <= fault ? NOP_INST : word;
        fault_q <= fault;
        cnt_q   <= cnt_q + 16'd1;
      end
    end
  end

  // Read above samples the pre-edge array, so a same-edge fetch sees the old byte.
  always_ff @(posedge clk) begin
    if (reset && prog_en) begin
      mem_q[prog_addr] <= prog_byte;
    end
  end

  assign bus.resp_valid = (state_q == StFull);
  assign bus.resp_inst  = inst_q;
  assign bus.resp_fault = fault_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Scoreboard bench for instruction_fetch_memory: expectations are queued on
// accept from a reference byte array and compared when responses are consumed.
module tb_instruction_fetch_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prog_en = 1'b0;
  logic [5:0]  prog_addr = 6'd0;
  logic [7:0]  prog_byte = 8'd0;
  logic [15:0] fetch_cnt;

  instruction_fetch_memory_if #(.ADDR_W(64)) bus ();

  instruction_fetch_memory #(
    .MEM_BYTES(64),
    .ADDR_W   (64),
    .NOP_INST (32'h00000013)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .prog_en  (prog_en),
    .prog_addr(prog_addr),
    .prog_byte(prog_byte),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] sb[$];
  logic [7:0]  mm[64];
  logic [15:0] cnt_model = 16'd0;
  logic        acc;
  logic [32:0] mon_exp;
  logic [7:0]  prog_bytes[4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_fetch(input logic [63:0] a);
    logic [5:0] b;
    b = a[5:0];
    if (a[1:0] != 2'b00 || a > 64'd60) return {1'b1, 32'h00000013};
    return {1'b0, mm[b + 6'd3], mm[b + 6'd2], mm[b + 6'd1], mm[b]};
  endfunction

  // One clock of stimulus; the model byte array updates only after the edge.
  task automatic drive_cycle(input logic v, input logic [63:0] a, input logic pe,
                             input logic [5:0] pa, input logic [7:0] pb,
                             output logic accepted);
    bus.req_valid = v;
    bus.req_addr  = a;
    prog_en       = pe;
    prog_addr     = pa;
    prog_byte     = pb;
    accepted      = 1'b0;
    @(negedge clk);
    if (v && bus.req_ready && reset) begin
      sb.push_back(model_fetch(a));
      cnt_model = cnt_model + 16'd1;
      accepted  = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pe && reset) mm[pa] = pb;
    bus.req_valid = 1'b0;
    prog_en       = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] a);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, a, 1'b0, 6'd0, 8'd0, ok);
      if (ok) break;
    end
    if (!ok) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    logic dummy;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 64'd0, 1'b0, 6'd0, 8'd0, dummy);
  endtask

  always @(negedge clk) begin
    if (reset && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_resp", 64'd1, 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        check_eq("resp_inst", {32'd0, bus.resp_inst}, {32'd0, mon_exp[31:0]});
        check_eq("resp_fault", {63'd0, bus.resp_fault}, {63'd0, mon_exp[32]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mm[i] = 8'h00;
    prog_bytes[0] = 8'h13;
    prog_bytes[1] = 8'h05;
    prog_bytes[2] = 8'h10;
    prog_bytes[3] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 64'd0;
    bus.resp_ready = 1'b0;

    @(posedge clk);
    #1;
    check_eq("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_eq("rst_resp_inst", {32'd0, bus.resp_inst}, 64'd0);
    check_eq("rst_resp_fault", {63'd0, bus.resp_fault}, 64'd0);
    check_eq("rst_fetch_cnt", {48'd0, fetch_cnt}, 64'd0);
    check_eq("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);

    reset = 1'b1;
    bus.resp_ready = 1'b1;
    fetch(64'd0);

    // Program 4..7 then fetch word 4; response must appear right after accept.
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 64'd0, 1'b1, 6'(4 + k), prog_bytes[k], acc);
    fetch(64'd4);
    check_eq("latency_valid", {63'd0, bus.resp_valid}, 64'd1);
    check_eq("word4_inst", {32'd0, bus.resp_inst}, {32'd0, 32'h00100513});
    check_eq("word4_fault", {63'd0, bus.resp_fault}, 64'd0);

    fetch(64'd2);
    check_eq("misalign_fault", {63'd0, bus.resp_fault}, 64'd1);
    check_eq("misalign_inst", {32'd0, bus.resp_inst}, {32'd0, 32'h00000013});
    fetch(64'd64);
    check_eq("range_fault", {63'd0, bus.resp_fault}, 64'd1);
    check_eq("range_inst", {32'd0, bus.resp_inst}, {32'd0, 32'h00000013});
    fetch(64'd60);
    fetch(64'd61);
    fetch(64'h1_0000_0004);
    check_eq("cnt_after_faults", {48'd0, fetch_cnt}, {48'd0, cnt_model});
    idle(2);
    check_eq("drained_valid", {63'd0, bus.resp_valid}, 64'd0);

    // Back-pressure: hold FULL for three cycles, then accept back-to-back.
    bus.resp_ready = 1'b0;
    fetch(64'd4);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 64'd60, 1'b0, 6'd0, 8'd0, acc);
      check_eq("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
      check_eq("stall_valid", {63'd0, bus.resp_valid}, 64'd1);
      check_eq("stall_inst", {32'd0, bus.resp_inst}, {32'd0, 32'h00100513});
    end
    bus.resp_ready = 1'b1;
    drive_cycle(1'b1, 64'd60, 1'b0, 6'd0, 8'd0, acc);
    check_eq("b2b_accept0", {63'd0, acc}, 64'd1);
    drive_cycle(1'b1, 64'd4, 1'b0, 6'd0, 8'd0, acc);
    check_eq("b2b_accept1", {63'd0, acc}, 64'd1);
    check_eq("b2b_valid", {63'd0, bus.resp_valid}, 64'd1);
    idle(2);

    // Same-edge program write and fetch of byte 8: old byte first, new on refetch.
    drive_cycle(1'b1, 64'd8, 1'b1, 6'd8, 8'hFF, acc);
    check_eq("rw_old_inst", {32'd0, bus.resp_inst}, 64'd0);
    fetch(64'd8);
    check_eq("rw_new_inst", {32'd0, bus.resp_inst}, {32'd0, 32'h000000FF});
    idle(1);

    // Asynchronous reset while FULL.
    bus.resp_ready = 1'b0;
    fetch(64'd4);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_eq("arst_inst", {32'd0, bus.resp_inst}, 64'd0);
    check_eq("arst_fault", {63'd0, bus.resp_fault}, 64'd0);
    check_eq("arst_cnt", {48'd0, fetch_cnt}, 64'd0);
    sb.delete();
    cnt_model = 16'd0;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 64'd4, 1'b1, 6'd4, 8'hAA, acc);
    check_eq("inrst_cnt", {48'd0, fetch_cnt}, 64'd0);
    check_eq("inrst_valid", {63'd0, bus.resp_valid}, 64'd0);
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    fetch(64'd4);
    check_eq("retained_inst", {32'd0, bus.resp_inst}, {32'd0, 32'h00100513});
    check_eq("post_rst_cnt", {48'd0, fetch_cnt}, 64'd1);

    // Run the counter round to its wrap point.
    begin
      int n;
      n = 65536 - int'(cnt_model);
      for (int i = 0; i < n; i++) drive_cycle(1'b1, 64'((i % 16) * 4), 1'b0, 6'd0, 8'd0, acc);
    end
    check_eq("cnt_wrap", {48'd0, fetch_cnt}, 64'd0);

    idle(3);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_memory.md
INSTRUCTION_FETCH_MEMORY -- requirements
Module: instruction_fetch_memory

Interface
REQ-001 Parameter MEM_BYTES, default 64: byte capacity; SHALL be a power of two, >= 4.
REQ-002 Parameter ADDR_W, default 64: request address width.
REQ-003 Parameter NOP_INST, default 32'h00000013: instruction returned on fault.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_addr  input  ADDR_W  byte address of the instruction.
REQ-009 resp_valid  output  1  response register holds a result.
REQ-010 resp_ready  input  1  consumer accepts the response this cycle.
REQ-011 resp_inst  output  32  fetched instruction.
REQ-012 resp_fault  output  1  request was misaligned or out of range.
REQ-013 prog_en  input  1  byte-write strobe for loading program memory.
REQ-014 prog_addr  input  log2(MEM_BYTES)  byte write address.
REQ-015 prog_byte  input  8  byte write data.
REQ-016 fetch_cnt  output  16  count of accepted requests.

Function
REQ-017 Storage SHALL be MEM_BYTES x 8-bit; contents SHALL NOT be cleared by reset and SHALL be zero at time 0.
REQ-018 Request accepted on a rising edge iff req_valid && req_ready.
REQ-019 req_ready SHALL equal !resp_valid || resp_ready (combinational; single-stage pipeline with back-pressure).
REQ-020 Response state machine: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-021 EMPTY -> FULL on accept; FULL -> EMPTY on resp_ready without accept; FULL stays FULL on accept with resp_ready, and the response register loads the new result.
REQ-022 FULL with resp_ready=0: resp_inst and resp_fault SHALL hold stable.
REQ-023 Latency: the response SHALL be visible one cycle after accept, i.e. resp_valid high after the accepting edge.
REQ-024 Fault when req_addr[1:0] != 0 or req_addr > MEM_BYTES-4; on fault resp_fault=1 and resp_inst=NOP_INST.
REQ-025 Non-fault: resp_fault=0 and resp_inst = {m[a+3], m[a+2], m[a+1], m[a]}, a = req_addr (little-endian).
REQ-026 prog_en SHALL write prog_byte to m[prog_addr] at the edge, independent of handshake state.
REQ-027 Simultaneous program write and accepted fetch covering the same byte: the fetch SHALL return the pre-write (old) byte.
REQ-028 fetch_cnt SHALL increment by 1 per accepted request, including faulting ones, and wrap from 16'hFFFF to 0.

Reset
REQ-029 reset low SHALL immediately force resp_valid=0, resp_inst=0, resp_fault=0, fetch_cnt=0, with state EMPTY.
REQ-030 Reset asserted mid-transaction SHALL discard any pending response; memory contents are retained.
REQ-031 While reset is low, no request is accepted and fetch_cnt holds 0; prog_en writes are ignored.

Verification
REQ-032 Apply prog_en writes of bytes 0x13,0x05,0x10,0x00 to addresses 4..7, then fetch 4 -> resp_inst=32'h00100513, resp_fault=0, one cycle later.
REQ-033 Fetch addresses 2 and 64 (MEM_BYTES=64) -> resp_fault=1 and resp_inst=32'h00000013 for both; fetch_cnt advances by 2.
REQ-034 Hold resp_ready=0 for 3 cycles with a response in FULL -> req_ready=0, resp_inst stable; then resp_ready=1 with a new request -> back-to-back accept with no bubble.
REQ-035 In the same cycle, prog_en writes 0xFF to address 8 and a fetch to address 8 is accepted -> response holds the old byte at [7:0]; a refetch returns 0xFF at [7:0].
REQ-036 Drive reset low while FULL -> resp_valid, resp_inst and fetch_cnt go to 0 without waiting for a clock edge; the next fetch after release returns the retained memory data.
REQ-037 Issue 65536 accepted requests -> fetch_cnt wraps to 0.
